alu_issue_ctrl: RTL

Sequencing front-end for the 16-bit 74181-style ALU datapath. It accepts operation requests over a valid/ready interface and translates each opcode into ALU select/mode/carry controls. It drives the operands onto the combinational ALU and registers the result with flags. Multiply is executed as a 16-step shift-add loop that reuses the ALU as the adder.

---
 rtl/alu_issue_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front-end for a 16-bit 74181-style ALU datapath.
// Define ALU_MUL_EN to build the shift-add multiply loop for op 7.
module alu_issue_ctrl #(
  parameter int W = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_zero,
  output logic         rsp_neg,
  output logic         rsp_err,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_ci,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y
);

  if (W != 16 || MUL_STEPS != W) begin : g_bad_cfg
    $error("alu_issue_ctrl: only W = MUL_STEPS = 16 is supported");
  end

  // {s, m, ci}
  localparam logic [5:0] CTL_IDLE = 6'b1111_1_0;
  localparam logic [5:0] CTL_ADD  = 6'b1001_0_0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
`ifdef ALU_MUL_EN
    , MUL_LOOP
`endif
  } state_t;

  state_t state;
  logic   err_q;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(MUL_STEPS);
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
`endif

  function automatic logic [5:0] ctl(input logic [2:0] op);
    logic [5:0] c;
    c = CTL_IDLE;
    unique case (op)
      3'd0: c = CTL_ADD;
      3'd1: c = 6'b0110_0_1;
      3'd2: c = 6'b1011_1_0;
      3'd3: c = 6'b1110_1_0;
      3'd4: c = 6'b0110_1_0;
      3'd5: c = 6'b0000_1_0;
      3'd6: c = 6'b1010_1_0;
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_neg   <= 1'b0;
      rsp_err   <= 1'b0;
      err_q     <= 1'b0;
      {alu_s, alu_m, alu_ci} <= CTL_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
`ifdef ALU_MUL_EN
      mplier    <= '0;
      cnt       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            err_q     <= 1'b0;
            if (req_op == 3'd7) begin
`ifdef ALU_MUL_EN
              // alu_a doubles as the accumulator, alu_b as the multiplicand
              state  <= MUL_LOOP;
              alu_a  <= '0;
              alu_b  <= req_a;
              mplier <= req_b;
              cnt    <= '0;
              {alu_s, alu_m, alu_ci} <=
                req_b[0] ? CTL_ADD : CTL_IDLE;
`else
              state <= EXEC;
              err_q <= 1'b1;
`endif
            end else begin
              state <= EXEC;
              alu_a <= req_a;
              alu_b <= req_b;
              {alu_s, alu_m, alu_ci} <= ctl(req_op);
            end
          end
        end
        EXEC: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_y     <= err_q ? '0 : alu_y;
          rsp_zero  <= err_q || (alu_y == '0);
          rsp_neg   <= !err_q && alu_y[W-1];
          {alu_s, alu_m, alu_ci} <= CTL_IDLE;
          alu_a     <= '0;
          alu_b     <= '0;
        end
`ifdef ALU_MUL_EN
        MUL_LOOP: begin
          cnt    <= cnt + 1'b1;
          mplier <= mplier >> 1;
          if (cnt == CW'(MUL_STEPS - 1)) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_y     <= alu_y;
            rsp_zero  <= (alu_y == '0);
            rsp_neg   <= alu_y[W-1];
            {alu_s, alu_m, alu_ci} <= CTL_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
          end else begin
            alu_a <= alu_y;
            alu_b <= alu_b << 1;
            {alu_s, alu_m, alu_ci} <=
              mplier[1] ? CTL_ADD : CTL_IDLE;
          end
        end
`endif
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
